// File: rtl/crc_pkg.sv
// Shared CRC definitions for the stream checker and the encoder side.
// Holds the bit-serial CRC step and the frame state encoding.
package crc_pkg;

    localparam int          MAXDW     = 512;
    localparam logic [7:0]  CRC8_POLY = 8'h07;
    localparam logic [7:0]  CRC8_INIT = 8'h00;

    typedef enum logic {
        IDLE,
        INFRAME
    } state_t;

    // MSB-first, non-reflected LFSR unrolled over the low dw data bits.
    function automatic logic [31:0] crc_step(
        input logic [31:0]      seed,
        input logic [MAXDW-1:0] data,
        input int               dw,
        input int               crcw,
        input logic [31:0]      poly
    );
        logic [31:0] c;
        logic [31:0] mask;
        logic        fb;
        mask = (crcw >= 32) ? '1 : ((32'h1 << crcw) - 32'h1);
        c    = seed & mask;
        for (int i = MAXDW - 1; i >= 0; i--) begin
            if (i < dw) begin
                fb = c[crcw-1] ^ data[i];
                c  = (c << 1) & mask;
                if (fb)
                    c = c ^ (poly & mask);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_stream_pipe.sv
// One-deep valid/ready register slice carrying a checked beat.
// Holds its contents stable while downstream stalls.
module crc_stream_pipe #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    output logic          up_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_sof,
    input  logic          in_eof,
    input  logic          in_err,
    input  logic          dn_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_sof,
    output logic          out_eof,
    output logic          out_err
);

    logic err_q;

    assign up_ready = ~out_valid | dn_ready;
    assign out_err  = out_valid & out_eof & err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            err_q     <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_sof   <= in_sof;
            out_eof   <= in_eof;
            err_q     <= in_err;
        end else if (dn_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/crc_stream_chk.sv
// Streaming CRC checker: accumulates CRC over framed beats, flags
// mismatches on EOF, detects framing violations and counts bad frames.
module crc_stream_chk
    import crc_pkg::*;
#(
    parameter int              DW   = 64,
    parameter int              CRCW = 8,
    parameter logic [CRCW-1:0] POLY = CRC8_POLY,
    parameter logic [CRCW-1:0] INIT = CRC8_INIT,
    parameter int              CNTW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [DW-1:0]   i_data,
    input  logic            i_sof,
    input  logic            i_eof,
    input  logic [CRCW-1:0] i_crc,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [DW-1:0]   o_data,
    output logic            o_sof,
    output logic            o_eof,
    output logic            o_haserr,
    output logic            o_proterr,
    output logic [CNTW-1:0] o_errcnt,
    input  logic            clr_cnt
);

    state_t          state_q;
    logic [CRCW-1:0] crc_acc;
    logic [CRCW-1:0] seed;
    logic [CRCW-1:0] nxt;
    logic            accept;
    logic            in_frame;
    logic            fwd;
    logic            proto;
    logic            load;
    logic            err;

    assign accept   = i_valid & o_ready;
    assign in_frame = (state_q == INFRAME);
    assign fwd      = i_sof | in_frame;
    assign proto    = i_sof ? in_frame : ~in_frame;
    assign load     = accept & fwd;
    assign seed     = i_sof ? INIT : crc_acc;
    assign nxt      = CRCW'(crc_step(32'(seed), MAXDW'(i_data),
                                     DW, CRCW, 32'(POLY)));
    assign err      = i_eof & (nxt != i_crc);

    // A SOF seen mid-frame abandons the old frame and opens a new one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            crc_acc   <= INIT;
            o_proterr <= 1'b0;
        end else begin
            o_proterr <= accept & proto;
            if (accept) begin
                crc_acc <= nxt;
                state_q <= (fwd & ~i_eof) ? INFRAME : IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            o_errcnt <= '0;
        else if (clr_cnt)
            o_errcnt <= '0;
        else if (o_valid & i_ready & o_haserr & ~&o_errcnt)
            o_errcnt <= o_errcnt + 1'b1;
    end

    crc_stream_pipe #(
        .DW (DW)
    ) u_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .up_ready  (o_ready),
        .in_data   (i_data),
        .in_sof    (i_sof),
        .in_eof    (i_eof),
        .in_err    (err),
        .dn_ready  (i_ready),
        .out_valid (o_valid),
        .out_data  (o_data),
        .out_sof   (o_sof),
        .out_eof   (o_eof),
        .out_err   (o_haserr)
    );

endmodule

// File: tb/tb_crc_stream_chk.sv
// Directed bench for crc_stream_chk with CRC-8 (07) and a 4-bit counter.
// Expected CRC values are hand-computed.
module tb_crc_stream_chk;

    localparam int CNTW = 4;

    logic            clk;
    logic            reset_n;
    logic            i_valid;
    logic            o_ready;
    logic [63:0]     i_data;
    logic            i_sof;
    logic            i_eof;
    logic [7:0]      i_crc;
    logic            o_valid;
    logic            i_ready;
    logic [63:0]     o_data;
    logic            o_sof;
    logic            o_eof;
    logic            o_haserr;
    logic            o_proterr;
    logic [CNTW-1:0] o_errcnt;
    logic            clr_cnt;

    int checks;
    int errors;

    crc_stream_chk #(
        .DW   (64),
        .CRCW (8),
        .POLY (8'h07),
        .INIT (8'h00),
        .CNTW (CNTW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_data    (i_data),
        .i_sof     (i_sof),
        .i_eof     (i_eof),
        .i_crc     (i_crc),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_sof     (o_sof),
        .o_eof     (o_eof),
        .o_haserr  (o_haserr),
        .o_proterr (o_proterr),
        .o_errcnt  (o_errcnt),
        .clr_cnt   (clr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] d, input logic s,
                         input logic e, input logic [7:0] c);
        i_valid = 1'b1;
        i_data  = d;
        i_sof   = s;
        i_eof   = e;
        i_crc   = c;
        cyc();
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_eof   = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        checks++;
        if (o_valid !== 1'b0 || o_data !== 64'h0 || o_sof !== 1'b0) begin
            errors++;
            $display("FAIL rst_out got v=%0b d=%h s=%0b exp 0", o_valid, o_data, o_sof);
        end
        checks++;
        if (o_eof !== 1'b0 || o_haserr !== 1'b0 || o_proterr !== 1'b0
            || o_errcnt !== '0) begin
            errors++;
            $display("FAIL rst_flags got e=%0b h=%0b p=%0b c=%0d exp 0",
                     o_eof, o_haserr, o_proterr, o_errcnt);
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready got %0b exp 1", o_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_single_good();
        drive(64'h1, 1'b1, 1'b1, 8'h07);
        checks++;
        if (o_valid !== 1'b1 || o_eof !== 1'b1 || o_sof !== 1'b1
            || o_data !== 64'h1) begin
            errors++;
            $display("FAIL t1_beat got v=%0b e=%0b s=%0b d=%h exp 1 1 1 1",
                     o_valid, o_eof, o_sof, o_data);
        end
        checks++;
        if (o_haserr !== 1'b0) begin
            errors++;
            $display("FAIL t1_haserr got %0b exp 0", o_haserr);
        end
        cyc();
        checks++;
        if (o_valid !== 1'b0 || o_errcnt !== 4'd0) begin
            errors++;
            $display("FAIL t1_drain got v=%0b c=%0d exp 0 0", o_valid, o_errcnt);
        end
    endtask

    task automatic test_single_bad();
        drive(64'h1, 1'b1, 1'b1, 8'h06);
        checks++;
        if (o_haserr !== 1'b1 || o_errcnt !== 4'd0) begin
            errors++;
            $display("FAIL t2_haserr got h=%0b c=%0d exp 1 0", o_haserr, o_errcnt);
        end
        cyc();
        checks++;
        if (o_errcnt !== 4'd1 || o_haserr !== 1'b0) begin
            errors++;
            $display("FAIL t2_count got c=%0d h=%0b exp 1 0", o_errcnt, o_haserr);
        end
        clr_cnt = 1'b1;
        cyc();
        clr_cnt = 1'b0;
        checks++;
        if (o_errcnt !== 4'd0) begin
            errors++;
            $display("FAIL t2_clr got %0d exp 0", o_errcnt);
        end
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        drive(64'h0, 1'b1, 1'b0, 8'h00);
        i_valid = 1'b1;
        i_data  = 64'h1;
        i_sof   = 1'b0;
        i_eof   = 1'b1;
        i_crc   = 8'h07;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_sof !== 1'b1
                || o_eof !== 1'b0 || o_data !== 64'h0) begin
                errors++;
                $display("FAIL t3_hold%0d got r=%0b v=%0b s=%0b e=%0b d=%h exp 0 1 1 0 0",
                         k, o_ready, o_valid, o_sof, o_eof, o_data);
            end
            cyc();
        end
        i_ready = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL t3_ready got %0b exp 1", o_ready);
        end
        cyc();
        i_valid = 1'b0;
        i_eof   = 1'b0;
        checks++;
        if (o_valid !== 1'b1 || o_sof !== 1'b0 || o_eof !== 1'b1
            || o_data !== 64'h1 || o_haserr !== 1'b0) begin
            errors++;
            $display("FAIL t3_beat2 got v=%0b s=%0b e=%0b d=%h h=%0b exp 1 0 1 1 0",
                     o_valid, o_sof, o_eof, o_data, o_haserr);
        end
        cyc();
        checks++;
        if (o_valid !== 1'b0 || o_errcnt !== 4'd0) begin
            errors++;
            $display("FAIL t3_drain got v=%0b c=%0d exp 0 0", o_valid, o_errcnt);
        end
    endtask

    task automatic test_protocol();
        drive(64'h5, 1'b0, 1'b0, 8'h00);
        checks++;
        if (o_proterr !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL t4_drop got p=%0b v=%0b exp 1 0", o_proterr, o_valid);
        end
        cyc();
        checks++;
        if (o_proterr !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL t4_pulse got p=%0b v=%0b exp 0 0", o_proterr, o_valid);
        end
        drive(64'hAA, 1'b1, 1'b0, 8'h00);
        checks++;
        if (o_proterr !== 1'b0 || o_valid !== 1'b1 || o_sof !== 1'b1) begin
            errors++;
            $display("FAIL t4_start got p=%0b v=%0b s=%0b exp 0 1 1",
                     o_proterr, o_valid, o_sof);
        end
        drive(64'h1, 1'b1, 1'b1, 8'h07);
        checks++;
        if (o_proterr !== 1'b1 || o_valid !== 1'b1 || o_eof !== 1'b1
            || o_haserr !== 1'b0) begin
            errors++;
            $display("FAIL t4_resof got p=%0b v=%0b e=%0b h=%0b exp 1 1 1 0",
                     o_proterr, o_valid, o_eof, o_haserr);
        end
        cyc();
        checks++;
        if (o_proterr !== 1'b0 || o_errcnt !== 4'd0) begin
            errors++;
            $display("FAIL t4_after got p=%0b c=%0d exp 0 0", o_proterr, o_errcnt);
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 16; k++)
            drive(64'h1, 1'b1, 1'b1, 8'h00);
        checks++;
        if (o_errcnt !== 4'd15 || o_haserr !== 1'b1) begin
            errors++;
            $display("FAIL t5_count15 got c=%0d h=%0b exp 15 1", o_errcnt, o_haserr);
        end
        cyc();
        checks++;
        if (o_errcnt !== 4'd15) begin
            errors++;
            $display("FAIL t5_sat got %0d exp 15", o_errcnt);
        end
        drive(64'h1, 1'b1, 1'b1, 8'h00);
        clr_cnt = 1'b1;
        cyc();
        clr_cnt = 1'b0;
        checks++;
        if (o_errcnt !== 4'd0) begin
            errors++;
            $display("FAIL t5_clrwins got %0d exp 0", o_errcnt);
        end
    endtask

    task automatic test_reset_midframe();
        drive(64'h1, 1'b1, 1'b1, 8'h06);
        cyc();
        checks++;
        if (o_errcnt !== 4'd1) begin
            errors++;
            $display("FAIL t6_precnt got %0d exp 1", o_errcnt);
        end
        drive(64'h0, 1'b1, 1'b0, 8'h00);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_data !== 64'h0 || o_sof !== 1'b0
            || o_eof !== 1'b0 || o_errcnt !== '0 || o_proterr !== 1'b0) begin
            errors++;
            $display("FAIL t6_rst got v=%0b d=%h s=%0b e=%0b c=%0d p=%0b exp 0",
                     o_valid, o_data, o_sof, o_eof, o_errcnt, o_proterr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        cyc();
        drive(64'h1, 1'b0, 1'b1, 8'h07);
        checks++;
        if (o_proterr !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL t6_idle got p=%0b v=%0b exp 1 0", o_proterr, o_valid);
        end
        drive(64'h1, 1'b1, 1'b1, 8'h07);
        checks++;
        if (o_valid !== 1'b1 || o_haserr !== 1'b0 || o_proterr !== 1'b0) begin
            errors++;
            $display("FAIL t6_clean got v=%0b h=%0b p=%0b exp 1 0 0",
                     o_valid, o_haserr, o_proterr);
        end
        cyc();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_sof   = 1'b0;
        i_eof   = 1'b0;
        i_crc   = '0;
        i_ready = 1'b1;
        clr_cnt = 1'b0;
        test_reset();
        test_single_good();
        test_single_bad();
        test_backpressure();
        test_protocol();
        test_saturate();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
